keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans the 4x4 matrix keypad by driving columns active-low and reading rows active-low, with
//  pull-ups on the rows. Debounces each press and emits one key code with a 1-cycle strobe per press.
//  Sits upstream of the input unit: o_col drives the pad, and o_key/o_valid feed digit/operator entry.
// PARAMETERS
//  SCAN_DIV        50_000  clock cycles per column dwell; a "tick" fires at the end of each dwell (1 ms @ 50 MHz)
//  DEBOUNCE_TICKS  8       consecutive agreeing ticks needed to accept a press or a release (>=1)
// PORTS
//  i_CLOCK    in   1  system clock
//  i_RESET    in   1  synchronous, active-high reset
//  i_row      in   4  keypad rows, active-low, asynchronous to i_CLOCK
//  o_col      out  4  column drive, active-low, exactly one bit low at all times
//  o_key      out  4  last accepted key code, held until the next accepted press
//  o_valid    out  1  1-cycle pulse when o_key updates
//  o_held     out  1  high while the accepted key remains pressed
//  o_state    out  2  FSM state for debug LEDs (SCAN=0, DEBOUNCE=1, HELD=2, RELEASE=3)
// BEHAVIOUR
//  - Reset values: o_col=4'b1110 (col0), o_key=0, o_valid=0, o_held=0, state=SCAN, all counters 0.
//    Reset is synchronous and overrides everything, including mid-debounce. No o_valid in the reset cycle.
//  - i_row passes through a 2-FF synchronizer. All decisions use the synced rows (2-cycle input latency).
//  - Dwell counter counts 0..SCAN_DIV-1 and wraps. tick=1 on the count==SCAN_DIV-1 cycle. It runs in every state.
//  - "Hit": exactly one synced row bit is low. Zero or two-plus low rows is "no hit"
//    (multi-key/ghost presses are rejected, never resolved).
//  - Key map, row r / col c -> code:
//      r0: 1,2,3,A(10)
//      r1: 4,5,6,B(11)
//      r2: 7,8,9,C(12)
//      r3: *(14),0,#(15),D(13)
//  - SCAN: on tick, if hit, latch row index and column index, set deb_cnt=1, and go to DEBOUNCE without rotating.
//    Otherwise rotate o_col col0->col1->col2->col3->col0 (wrap).
//  - DEBOUNCE: column frozen. On tick:
//      same single row still low -> deb_cnt++
//      otherwise -> deb_cnt=0, rotate to the next column, go to SCAN
//    When deb_cnt reaches DEBOUNCE_TICKS: o_key<=code and o_valid=1 for exactly one cycle
//    (the cycle after that tick), o_held<=1, go to HELD.
//    With DEBOUNCE_TICKS=1, acceptance happens on the detecting tick itself.
//  - HELD: column frozen, no repeats. On tick with the latched row not low: rel_cnt=1, go to RELEASE.
//  - RELEASE: on tick:
//      latched row low again -> rel_cnt=0, back to HELD (bounce)
//      otherwise -> rel_cnt++
//    When rel_cnt reaches DEBOUNCE_TICKS: o_held<=0, rotate to the next column, go to SCAN.
//  - A second key pressed while in HELD/RELEASE is ignored until the release completes.
//    A different row going low in HELD does not count as a release.
//  - Worst-case press latency: 4*SCAN_DIV + DEBOUNCE_TICKS*SCAN_DIV + 3 cycles.
//  - Counter widths use $clog2. DEBOUNCE_TICKS=1 must be supported.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_TICKS=3; pad model shorts row r to col c when key held)
//  1. Reset, no keys -> o_col cycles 1110,1101,1011,0111,1110 every 4 clks; o_valid never pulses; o_state=0.
//  2. Hold key '5' (r1,c1) for 40 clks -> exactly one o_valid pulse with o_key=5, o_held=1 until release;
//     after release plus 3 quiet ticks, o_held=0 and scanning resumes from col2.
//  3. Key '8' bounces (down 1 tick, up 1 tick, then down 10 ticks) -> no pulse on the bounce;
//     a single pulse with o_key=8 after 3 steady ticks.
//  4. Hold '1' and '4' together (same column) -> no o_valid. Release '4' -> one pulse, o_key=1.
//  5. Press '#' (r3,c2) and hold; then also press 'D' during HELD -> one pulse, o_key=15; no pulse for 'D'
//     until '#' has been released and 'D' re-debounced (o_key=13).
//  6. Assert i_RESET for 1 clk mid-DEBOUNCE of key '0' -> next cycle o_col=1110, o_state=0,
//     o_key=0, and no o_valid pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low column drive, synced active-low rows,
// per-key debounce, one strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       i_CLOCK,
  input  logic       i_RESET,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key,
  output logic       o_valid,
  output logic       o_held,
  output logic [1:0] o_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] div_cnt;
  logic          tick, hit, accept;
  logic [1:0]    hit_row;
  logic [1:0]    col_idx, col_nx;
  logic [1:0]    row_lat, row_nx;
  logic [DW-1:0] deb_cnt, deb_nx;
  logic [DW-1:0] rel_cnt, rel_nx;
  logic [3:0]    code;

  assign tick = (div_cnt == DIV_MAX);

  // Only a single low row is a hit; ghosting patterns are dropped.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    unique case (row_s2)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    code = 4'd0;
    unique case ({hit_row, col_idx})
      4'd0:  code = 4'd1;
      4'd1:  code = 4'd2;
      4'd2:  code = 4'd3;
      4'd3:  code = 4'd10;
      4'd4:  code = 4'd4;
      4'd5:  code = 4'd5;
      4'd6:  code = 4'd6;
      4'd7:  code = 4'd11;
      4'd8:  code = 4'd7;
      4'd9:  code = 4'd8;
      4'd10: code = 4'd9;
      4'd11: code = 4'd12;
      4'd12: code = 4'd14;
      4'd13: code = 4'd0;
      4'd14: code = 4'd15;
      4'd15: code = 4'd13;
    endcase
  end

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) state <= SCAN;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    col_nx   = col_idx;
    row_nx   = row_lat;
    deb_nx   = deb_cnt;
    rel_nx   = rel_cnt;
    accept   = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (hit) begin
            row_nx   = hit_row;
            deb_nx   = DW'(1);
            state_nx = DEBOUNCE;
            if (DEB_MAX == DW'(1)) begin
              accept   = 1'b1;
              state_nx = HELD;
            end
          end else begin
            col_nx = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && hit_row == row_lat) begin
            deb_nx = deb_cnt + DW'(1);
            if (deb_nx == DEB_MAX) begin
              accept   = 1'b1;
              state_nx = HELD;
            end
          end else begin
            deb_nx   = '0;
            col_nx   = col_idx + 2'd1;
            state_nx = SCAN;
          end
        end
        HELD: begin
          if (row_s2[row_lat]) begin
            rel_nx   = DW'(1);
            state_nx = RELEASE;
            if (DEB_MAX == DW'(1)) begin
              rel_nx   = '0;
              col_nx   = col_idx + 2'd1;
              state_nx = SCAN;
            end
          end
        end
        RELEASE: begin
          if (!row_s2[row_lat]) begin
            rel_nx   = '0;
            state_nx = HELD;
          end else begin
            rel_nx = rel_cnt + DW'(1);
            if (rel_nx == DEB_MAX) begin
              rel_nx   = '0;
              col_nx   = col_idx + 2'd1;
              state_nx = SCAN;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      div_cnt <= '0;
      col_idx <= 2'd0;
      row_lat <= 2'd0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      o_key   <= 4'd0;
      o_valid <= 1'b0;
    end else begin
      row_s1  <= i_row;
      row_s2  <= row_s1;
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      col_idx <= col_nx;
      row_lat <= row_nx;
      deb_cnt <= deb_nx;
      rel_cnt <= rel_nx;
      o_valid <= accept;
      if (accept) o_key <= code;
    end
  end

  always_comb begin
    o_col = 4'b1110;
    unique case (col_idx)
      2'd0: o_col = 4'b1110;
      2'd1: o_col = 4'b1101;
      2'd2: o_col = 4'b1011;
      2'd3: o_col = 4'b0111;
    endcase
    o_state = state;
    o_held  = (state == HELD) || (state == RELEASE);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: pad model, key-level reference model,
// per-cycle compare plus directed literal checks.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       i_RESET = 1'b1;
  logic [3:0] i_row;
  logic [3:0] o_col, o_key;
  logic       o_valid, o_held;
  logic [1:0] o_state;
  logic [15:0] pressed = '0;

  int vectors = 0;
  int miscompares = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DEB)) dut (
    .i_CLOCK(clk), .i_RESET(i_RESET), .i_row(i_row),
    .o_col(o_col), .o_key(o_key), .o_valid(o_valid),
    .o_held(o_held), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Pad: row r reads low when a pressed key in row r sits on a driven column.
  always_comb begin
    i_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && o_col[c] == 1'b0) i_row[r] = 1'b0;
  end

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11},
                        '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: tick schedule, key detection and debounce by key events.
  bit         armed = 0;
  int         m_state, m_col, m_row, m_key, m_deb, m_rel, m_dwell;
  bit         m_valid;
  logic [3:0] rq[$];
  logic [3:0] sr;
  int         nlow, lr;
  bit         tk;

  always @(posedge clk) begin
    if (i_RESET) begin
      armed = 1; m_state = 0; m_col = 0; m_row = 0; m_key = 0;
      m_valid = 0; m_deb = 0; m_rel = 0; m_dwell = 0;
      rq.delete(); rq.push_back(4'hF); rq.push_back(4'hF);
    end else if (armed) begin
      sr = rq.pop_front();
      rq.push_back(i_row);
      tk = (m_dwell == SD - 1);
      m_dwell = (m_dwell + 1) % SD;
      m_valid = 0;
      nlow = 0; lr = 0;
      for (int i = 0; i < 4; i++)
        if (!sr[i]) begin nlow++; lr = i; end
      if (tk) begin
        case (m_state)
          0: if (nlow == 1) begin m_row = lr; m_deb = 1; m_state = 1; end
             else m_col = (m_col + 1) % 4;
          1: if (nlow == 1 && lr == m_row) m_deb++;
             else begin m_deb = 0; m_col = (m_col + 1) % 4; m_state = 0; end
          2: if (sr[m_row]) begin m_rel = 1; m_state = 3; end
          default: if (!sr[m_row]) begin m_rel = 0; m_state = 2; end
                   else m_rel++;
        endcase
        if (m_state == 1 && m_deb >= DEB) begin
          m_valid = 1; m_key = keymap[m_row][m_col]; m_state = 2;
        end
        if (m_state == 3 && m_rel >= DEB) begin
          m_rel = 0; m_state = 0; m_col = (m_col + 1) % 4;
        end
      end
    end
  end

  int         pulses = 0;
  logic [3:0] last_key = 4'd0;
  logic [3:0] fall_col = 4'd0;
  logic       prev_held = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      chk("col",   {4'd0, o_col},   {4'd0, 4'hF ^ (4'h1 << m_col)});
      chk("state", {6'd0, o_state}, 8'(m_state));
      chk("key",   {4'd0, o_key},   8'(m_key));
      chk("valid", {7'd0, o_valid}, {7'd0, m_valid});
      chk("held",  {7'd0, o_held},  {7'd0, (m_state >= 2)});
      if (o_valid === 1'b1) begin pulses++; last_key = o_key; end
      if (prev_held === 1'b1 && o_held === 1'b0) fall_col = o_col;
      prev_held = o_held;
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic key(int r, int c, bit down);
    pressed[r*4+c] = down;
  endtask

  logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int base;
  int n;

  initial begin
    // 1: reset and idle scan
    i_RESET = 1'b1;
    cycles(2);
    i_RESET = 1'b0;
    chk("rst_col", {4'd0, o_col}, 8'h0E);
    chk("rst_state", {6'd0, o_state}, 8'd0);
    chk("rst_key", {4'd0, o_key}, 8'd0);
    chk("rst_valid", {7'd0, o_valid}, 8'd0);
    chk("rst_held", {7'd0, o_held}, 8'd0);
    for (int k = 0; k < 20; k++) begin
      chk("idle_col", {4'd0, o_col}, {4'd0, pat[(k / 4) % 4]});
      cycles(1);
    end
    cycles(20);
    chk("idle_pulses", 8'(pulses), 8'd0);

    // 2: hold '5'
    base = pulses;
    key(1, 1, 1);
    cycles(40);
    chk("k5_pulses", 8'(pulses - base), 8'd1);
    chk("k5_key", {4'd0, last_key}, 8'd5);
    chk("k5_held", {7'd0, o_held}, 8'd1);
    key(1, 1, 0);
    cycles(40);
    chk("k5_released", {7'd0, o_held}, 8'd0);
    chk("k5_pulses_after", 8'(pulses - base), 8'd1);
    chk("k5_resume_col", {4'd0, fall_col}, 8'h0B);

    // 3: '8' bounces once, then held
    n = 0;
    while (o_col == 4'b1101 && n < 40) begin cycles(1); n++; end
    while (o_col != 4'b1101 && n < 40) begin cycles(1); n++; end
    chk("k8_align", {4'd0, o_col}, 8'h0D);
    base = pulses;
    key(2, 1, 1);
    cycles(4);
    chk("k8_debounce", {6'd0, o_state}, 8'd1);
    key(2, 1, 0);
    cycles(4);
    chk("k8_bounce_state", {6'd0, o_state}, 8'd0);
    chk("k8_bounce_col", {4'd0, o_col}, 8'h0B);
    key(2, 1, 1);
    cycles(40);
    chk("k8_pulses", 8'(pulses - base), 8'd1);
    chk("k8_key", {4'd0, last_key}, 8'd8);
    key(2, 1, 0);
    cycles(40);

    // 4: '1' and '4' together, then '4' released
    base = pulses;
    key(0, 0, 1); key(1, 0, 1);
    cycles(40);
    chk("ghost_pulses", 8'(pulses - base), 8'd0);
    key(1, 0, 0);
    cycles(40);
    chk("k1_pulses", 8'(pulses - base), 8'd1);
    chk("k1_key", {4'd0, last_key}, 8'd1);
    key(0, 0, 0);
    cycles(40);

    // 5: '#' held, 'D' pressed during HELD
    base = pulses;
    key(3, 2, 1);
    cycles(40);
    chk("kh_pulses", 8'(pulses - base), 8'd1);
    chk("kh_key", {4'd0, last_key}, 8'd15);
    key(3, 3, 1);
    cycles(40);
    chk("kd_blocked", 8'(pulses - base), 8'd1);
    chk("kh_still_held", {7'd0, o_held}, 8'd1);
    key(3, 2, 0);
    cycles(60);
    chk("kd_pulses", 8'(pulses - base), 8'd2);
    chk("kd_key", {4'd0, last_key}, 8'd13);
    key(3, 3, 0);
    cycles(40);

    // 6: reset mid-debounce of '0'
    base = pulses;
    key(3, 1, 1);
    n = 0;
    while (o_state != 2'd1 && n < 60) begin cycles(1); n++; end
    chk("k0_debounce", {6'd0, o_state}, 8'd1);
    i_RESET = 1'b1;
    cycles(1);
    i_RESET = 1'b0;
    key(3, 1, 0);
    chk("mid_rst_col", {4'd0, o_col}, 8'h0E);
    chk("mid_rst_state", {6'd0, o_state}, 8'd0);
    chk("mid_rst_key", {4'd0, o_key}, 8'd0);
    chk("mid_rst_valid", {7'd0, o_valid}, 8'd0);
    cycles(40);
    chk("mid_rst_pulses", 8'(pulses - base), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
